multicycle_control: RTL and testbench

//  Moore FSM that sequences the multicycle RV64 datapath (PC, IR, regfile, ALU, data memory).

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle RV64 controller (master) and its datapath (slave).
// IR word and ALU zero flow in; every datapath control flag and the debug view flow out.
interface multicycle_control_if;
  logic [31:0] instruction;
  logic        alu_zero;

  logic        PCWrite;
  logic        PCWriteCond;
  logic        PCSource;
  logic        ALUSrcA;
  logic        LoadAOut;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        RegWrite;
  logic        LoadRegA;
  logic        LoadRegB;
  logic        MemToReg;
  logic        DMemOp;
  logic        LoadMDR;
  logic        IMemRead;
  logic        IRWrite;

  logic        halted;
  logic [31:0] instr_retired;
  logic [3:0]  state_dbg;

  modport master (
    input  instruction, alu_zero,
    output PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, ALUSrcB, ALUOp,
           RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite,
           halted, instr_retired, state_dbg
  );

  modport slave (
    output instruction, alu_zero,
    input  PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, ALUSrcB, ALUOp,
           RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite,
           halted, instr_retired, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV64 datapath: one state per cycle, flags decoded from state.
// Latency: R/I/sd 5, ld 6, branch taken 4 / not taken 5 cycles; no backpressure, illegal op halts.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b001,
  parameter logic [2:0] ALU_SUB = 3'b010
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_IR_LD    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_PC_INC   = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_store;
  logic        r_is_sub;
  logic [31:0] r_instr_retired;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_ld;
  logic        w_is_sd;
  logic        w_is_br;
  logic        w_taken;
  logic        w_retire;
  logic        w_unused_ir;

  assign w_op        = bus.instruction[6:0];
  assign w_f3        = bus.instruction[14:12];
  assign w_f7        = bus.instruction[31:25];
  assign w_unused_ir = ^{bus.instruction[24:15], bus.instruction[11:7]};

  assign w_is_r  = (w_op == OP_R) && (w_f3 == 3'b000) &&
                   ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000));
  assign w_is_i  = (w_op == OP_I) && (w_f3 == 3'b000);
  assign w_is_ld = (w_op == OP_LD) && (w_f3 == 3'b011);
  assign w_is_sd = (w_op == OP_SD) && (w_f3 == 3'b011);
  assign w_is_br = (w_op == OP_BR) && ((w_f3 == 3'b000) || (w_f3 == 3'b001));

  // f3[0] separates bne from beq; only meaningful while in BRANCH
  assign w_taken = (r_state == S_BRANCH) && (w_f3[0] ? !bus.alu_zero : bus.alu_zero);

  assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                    (r_state == S_MEM_WR) || (r_state == S_PC_INC) || w_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ld/sd and add/sub choices are captured in DECODE so later states never re-read the IR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_store <= 1'b0;
      r_is_sub   <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_store <= w_is_sd;
      r_is_sub   <= w_f7[5];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_retired <= 32'd0;
    end else if (w_retire) begin
      r_instr_retired <= r_instr_retired + 32'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = S_IR_LD;
      S_IR_LD:    w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_r)                  w_next = S_EXEC_R;
        else if (w_is_i)             w_next = S_EXEC_I;
        else if (w_is_ld || w_is_sd) w_next = S_MEM_ADDR;
        else if (w_is_br)            w_next = S_BRANCH;
        else                         w_next = S_HALT;
      end
      S_EXEC_R:   w_next = S_ALU_WB;
      S_EXEC_I:   w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = S_FETCH;
      S_BRANCH:   w_next = w_taken ? S_FETCH : S_PC_INC;
      S_PC_INC:   w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_HALT;
    endcase
  end

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_pc_source;
  logic       w_alu_src_a;
  logic       w_load_aout;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_op;
  logic       w_reg_write;
  logic       w_load_reg_a;
  logic       w_load_reg_b;
  logic       w_mem_to_reg;
  logic       w_dmem_op;
  logic       w_load_mdr;
  logic       w_imem_read;
  logic       w_ir_write;
  logic       w_halted;

  // Flags are forced low while reset is held so an aborted write cannot land on the next edge
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_load_aout     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 3'b000;
    w_reg_write     = 1'b0;
    w_load_reg_a    = 1'b0;
    w_load_reg_b    = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_dmem_op       = 1'b0;
    w_load_mdr      = 1'b0;
    w_imem_read     = 1'b0;
    w_ir_write      = 1'b0;
    w_halted        = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          w_imem_read = 1'b1;
        end
        S_IR_LD: begin
          w_imem_read = 1'b1;
          w_ir_write  = 1'b1;
        end
        S_DECODE: begin
          w_load_reg_a = 1'b1;
          w_load_reg_b = 1'b1;
          w_alu_src_b  = 2'b11;
          w_alu_op     = ALU_ADD;
          w_load_aout  = 1'b1;
        end
        S_EXEC_R: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b00;
          w_alu_op    = r_is_sub ? ALU_SUB : ALU_ADD;
          w_load_aout = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
          w_alu_op    = ALU_ADD;
          w_load_aout = 1'b1;
        end
        S_ALU_WB: begin
          w_reg_write = 1'b1;
          w_pc_write  = 1'b1;
          w_alu_src_b = 2'b01;
          w_alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          w_load_mdr = 1'b1;
        end
        S_MEM_WB: begin
          w_reg_write  = 1'b1;
          w_mem_to_reg = 1'b1;
          w_pc_write   = 1'b1;
          w_alu_src_b  = 2'b01;
          w_alu_op     = ALU_ADD;
        end
        S_MEM_WR: begin
          w_dmem_op   = 1'b1;
          w_pc_write  = 1'b1;
          w_alu_src_b = 2'b01;
          w_alu_op    = ALU_ADD;
        end
        S_BRANCH: begin
          w_alu_src_a     = 1'b1;
          w_alu_src_b     = 2'b00;
          w_alu_op        = ALU_SUB;
          w_pc_source     = 1'b1;
          w_pc_write_cond = 1'b1;
          w_pc_write      = w_taken;
        end
        S_PC_INC: begin
          w_pc_write  = 1'b1;
          w_alu_src_b = 2'b01;
          w_alu_op    = ALU_ADD;
        end
        S_HALT: begin
          w_halted = 1'b1;
        end
        default: begin
          w_halted = 1'b0;
        end
      endcase
    end
  end

  assign bus.PCWrite       = w_pc_write;
  assign bus.PCWriteCond   = w_pc_write_cond;
  assign bus.PCSource      = w_pc_source;
  assign bus.ALUSrcA       = w_alu_src_a;
  assign bus.LoadAOut      = w_load_aout;
  assign bus.ALUSrcB       = w_alu_src_b;
  assign bus.ALUOp         = w_alu_op;
  assign bus.RegWrite      = w_reg_write;
  assign bus.LoadRegA      = w_load_reg_a;
  assign bus.LoadRegB      = w_load_reg_b;
  assign bus.MemToReg      = w_mem_to_reg;
  assign bus.DMemOp        = w_dmem_op;
  assign bus.LoadMDR       = w_load_mdr;
  assign bus.IMemRead      = w_imem_read;
  assign bus.IRWrite       = w_ir_write;
  assign bus.halted        = w_halted;
  assign bus.instr_retired = r_instr_retired;
  assign bus.state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: a small behavioural RV64 datapath runs a fixed program under the controller.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.ALU_ADD(3'b001), .ALU_SUB(3'b010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // flag order: PCWrite PCWriteCond PCSource ALUSrcA LoadAOut | ALUSrcB | ALUOp | RegWrite LoadRegA LoadRegB MemToReg DMemOp LoadMDR IMemRead IRWrite
  localparam logic [17:0] F_ZERO    = {5'b00000, 2'b00, 3'b000, 8'b00000000};
  localparam logic [17:0] F_FETCH   = {5'b00000, 2'b00, 3'b000, 8'b00000010};
  localparam logic [17:0] F_DECODE  = {5'b00001, 2'b11, 3'b001, 8'b01100000};
  localparam logic [17:0] F_EXEC_RS = {5'b00011, 2'b00, 3'b010, 8'b00000000};
  localparam logic [17:0] F_ALU_WB  = {5'b10000, 2'b01, 3'b001, 8'b10000000};
  localparam logic [17:0] F_MEM_RD  = {5'b00000, 2'b00, 3'b000, 8'b00000100};
  localparam logic [17:0] F_MEM_WR  = {5'b10000, 2'b01, 3'b001, 8'b00001000};
  localparam logic [17:0] F_BR_T    = {5'b11110, 2'b00, 3'b010, 8'b00000000};
  localparam logic [17:0] F_BR_NT   = {5'b01110, 2'b00, 3'b010, 8'b00000000};

  logic [17:0] fl;
  assign fl = {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.ALUSrcA, bus.LoadAOut,
               bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.LoadRegA, bus.LoadRegB,
               bus.MemToReg, bus.DMemOp, bus.LoadMDR, bus.IMemRead, bus.IRWrite};

  logic [31:0] imem [32];
  logic [63:0] rf   [32];
  logic [63:0] dmem [16];
  logic [63:0] pc, a_reg, b_reg, aluout, mdr;
  logic [31:0] ir;
  logic        dp_init = 1'b1;
  int          n_regwr, n_dmem, n_pcwr;
  logic [63:0] imm, src_a, src_b, alu_res;

  always_comb begin
    imm = {{52{ir[31]}}, ir[31:20]};
    if (ir[6:0] == 7'b0100011) imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
    if (ir[6:0] == 7'b1100011) imm = {{52{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8]};
    src_a = bus.ALUSrcA ? a_reg : pc;
    case (bus.ALUSrcB)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = 64'd4;
      2'b10:   src_b = imm;
      default: src_b = imm << 1;
    endcase
    alu_res = (bus.ALUOp == 3'b010) ? (src_a - src_b) : (src_a + src_b);
  end

  assign bus.alu_zero    = (alu_res == 64'd0);
  assign bus.instruction = ir;

  always @(posedge clk) begin
    if (dp_init) begin
      pc <= 64'd0;
      ir <= 32'd0;
      n_regwr <= 0;
      n_dmem <= 0;
      n_pcwr <= 0;
      for (int i = 0; i < 32; i++) rf[i] <= 64'd0;
      for (int j = 0; j < 16; j++) dmem[j] <= 64'd0;
      rf[1] <= 64'd5;
      rf[2] <= 64'd7;
      rf[6] <= 64'd5;
      dmem[2] <= 64'h1122334455667788;
    end else begin
      if (bus.IRWrite) ir <= imem[pc[6:2]];
      if (bus.LoadRegA) a_reg <= rf[ir[19:15]];
      if (bus.LoadRegB) b_reg <= rf[ir[24:20]];
      if (bus.LoadAOut) aluout <= alu_res;
      if (bus.LoadMDR) mdr <= dmem[aluout[6:3]];
      if (bus.PCWrite) begin
        pc <= bus.PCSource ? aluout : alu_res;
        n_pcwr <= n_pcwr + 1;
      end
      if (bus.DMemOp) begin
        dmem[aluout[6:3]] <= b_reg;
        n_dmem <= n_dmem + 1;
      end
      if (bus.RegWrite) begin
        if (ir[11:7] != 5'd0) rf[ir[11:7]] <= bus.MemToReg ? mdr : aluout;
        n_regwr <= n_regwr + 1;
      end
    end
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s_reg, s_dm, s_pc;

  initial begin
    for (int k = 0; k < 32; k++) imem[k] = 32'h0000007F;
    imem[0] = 32'h002081B3;  // add  x3,x1,x2
    imem[1] = 32'h40208233;  // sub  x4,x1,x2
    imem[2] = 32'h01003283;  // ld   x5,16(x0)
    imem[3] = 32'h00303823;  // sd   x3,16(x0)
    imem[4] = 32'h00208463;  // beq  x1,x2,+8
    imem[5] = 32'h00608463;  // beq  x1,x6,+8
    imem[7] = 32'h00209463;  // bne  x1,x2,+8
    imem[9] = 32'h00609463;  // bne  x1,x6,+8
    imem[10] = 32'h00103C23; // sd   x1,24(x0)

    step(2);
    dp_init = 1'b0;
    check("rst_state", bus.state_dbg, 4'd0);
    check("rst_flags", fl, F_ZERO);
    check("rst_count", bus.instr_retired, 32'd0);
    check("rst_halted", bus.halted, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("fetch_flags", fl, F_FETCH);

    // add
    step(2);
    check("decode_flags", fl, F_DECODE);
    step(2);
    check("add_alu_wb_state", bus.state_dbg, 4'd5);
    step(1);
    check("add_x3", rf[3], 64'd12);
    check("add_pc", pc, 64'd4);
    check("add_count", bus.instr_retired, 32'd1);

    // sub
    step(3);
    check("sub_exec_flags", fl, F_EXEC_RS);
    step(2);
    check("sub_x4", rf[4], 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_pc", pc, 64'd8);

    // ld
    step(4);
    check("ld_mem_rd_flags", fl, F_MEM_RD);
    step(1);
    check("ld_mem_wb_state", bus.state_dbg, 4'd8);
    check("ld_x5_pending", rf[5], 64'd0);
    step(1);
    check("ld_x5", rf[5], 64'h1122334455667788);
    check("ld_pc", pc, 64'd12);
    check("ld_count", bus.instr_retired, 32'd3);

    // sd
    s_dm = n_dmem;
    step(4);
    check("sd_mem_wr_flags", fl, F_MEM_WR);
    step(1);
    check("sd_dmem", dmem[2], 64'd12);
    check("sd_one_cycle", n_dmem - s_dm, 1);
    check("sd_pc", pc, 64'd16);
    check("sd_count", bus.instr_retired, 32'd4);

    // beq not taken, beq taken, bne taken, bne not taken
    step(3);
    check("beq_nt_flags", fl, F_BR_NT);
    step(1);
    check("beq_nt_pc_inc", bus.state_dbg, 4'd11);
    step(1);
    check("beq_nt_pc", pc, 64'd20);
    step(3);
    check("beq_t_flags", fl, F_BR_T);
    step(1);
    check("beq_t_state", bus.state_dbg, 4'd0);
    check("beq_t_pc", pc, 64'd28);
    check("beq_t_count", bus.instr_retired, 32'd6);
    step(4);
    check("bne_t_pc", pc, 64'd36);
    step(4);
    check("bne_nt_pc_inc", bus.state_dbg, 4'd11);
    step(1);
    check("bne_nt_pc", pc, 64'd40);
    check("bne_nt_count", bus.instr_retired, 32'd8);

    // reset during MEM_WR
    step(4);
    check("abort_sd_state", bus.state_dbg, 4'd9);
    s_dm = n_dmem;
    #2;
    reset = 1'b0;
    #1;
    check("abort_sd_flags", fl, F_ZERO);
    check("abort_sd_rst_state", bus.state_dbg, 4'd0);
    check("abort_sd_count", bus.instr_retired, 32'd0);
    step(2);
    check("abort_sd_no_write", n_dmem - s_dm, 0);
    check("abort_sd_dmem", dmem[3], 64'd0);
    check("abort_sd_pc", pc, 64'd40);

    // reset during ALU_WB
    imem[10] = 32'h00208433; // add x8,x1,x2
    @(negedge clk);
    reset = 1'b1;
    step(4);
    check("abort_wb_flags_live", fl, F_ALU_WB);
    #2;
    reset = 1'b0;
    #1;
    check("abort_wb_flags", fl, F_ZERO);
    check("abort_wb_state", bus.state_dbg, 4'd0);
    step(2);
    check("abort_wb_x8", rf[8], 64'd0);
    check("abort_wb_pc", pc, 64'd40);

    // counter wrap on addi
    imem[10] = 32'h00300393; // addi x7,x0,3
    @(negedge clk);
    reset = 1'b1;
    force dut.r_instr_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_retired;
    step(5);
    check("wrap_count", bus.instr_retired, 32'd0);
    check("wrap_x7", rf[7], 64'd3);
    check("wrap_pc", pc, 64'd44);

    // illegal opcode at pc 44
    s_reg = n_regwr;
    s_dm  = n_dmem;
    s_pc  = n_pcwr;
    step(3);
    check("halt_state", bus.state_dbg, 4'd12);
    check("halt_flag", bus.halted, 1'b1);
    check("halt_flags", fl, F_ZERO);
    step(6);
    check("halt_absorb", bus.state_dbg, 4'd12);
    check("halt_no_regwr", n_regwr - s_reg, 0);
    check("halt_no_dmem", n_dmem - s_dm, 0);
    check("halt_no_pcwr", n_pcwr - s_pc, 0);
    check("halt_pc", pc, 64'd44);
    #2;
    reset = 1'b0;
    #1;
    check("halt_rst_state", bus.state_dbg, 4'd0);
    check("halt_rst_flag", bus.halted, 1'b0);
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
